// File: rtl/win3_pkg.sv
// Shared constants and types for the 3x3 window generator.
// Window layout: pixel k = row*3 + col sits at bits [24k+23:24k],
// row 0 = top (oldest line), col 0 = left (oldest column).
package win3_pkg;
  localparam int PIX_BITS = 24;
  localparam int WIN_BITS = 9 * PIX_BITS;

  // channel slice offsets inside one RGB888 pixel
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // pixel indices inside the packed window
  localparam int P00 = 0;
  localparam int P01 = 1;
  localparam int P02 = 2;
  localparam int P10 = 3;
  localparam int P11 = 4;
  localparam int P12 = 5;
  localparam int P20 = 6;
  localparam int P21 = 7;
  localparam int P22 = 8;

  typedef logic [PIX_BITS-1:0] pix_t;
  // [row][col][bit]: packed so that [r][c] lands at bit (r*3+c)*PIX_BITS,
  // which is exactly the convolution stage's input packing.
  typedef logic [2:0][2:0][PIX_BITS-1:0] win_t;
endpackage

// File: rtl/window3x3_linebuf_if.sv
// Pixel-in / window-out streaming bundle for window3x3_linebuf.
// o_eof exists only when WIN3_EOF_FLAG_EN is defined.
interface window3x3_linebuf_if;
  import win3_pkg::*;

  logic [PIX_BITS-1:0] i_pix;
  logic                i_valid;
  logic                i_ready;
  logic [WIN_BITS-1:0] o_window;
  logic                o_valid;
  logic                o_ready;
`ifdef WIN3_EOF_FLAG_EN
  logic                o_eof;
`endif

  // master: pixel source / window sink
  modport master (
    output i_pix, i_valid, o_ready,
    input  i_ready, o_window, o_valid
`ifdef WIN3_EOF_FLAG_EN
    , input o_eof
`endif
  );

  // slave: the window generator itself
  modport slave (
    input  i_pix, i_valid, o_ready,
    output i_ready, o_window, o_valid
`ifdef WIN3_EOF_FLAG_EN
    , output o_eof
`endif
  );
endinterface

// File: rtl/win3_line_buffer.sv
// One image row of delay: DEPTH entries, combinational read, write on en.
// The read sees the old entry in the cycle of a write to the same address
// (read-before-write). No reset: contents are only used once valid.
module win3_line_buffer #(
  parameter int DEPTH = 640,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // write the new row entry; old value already presented on rdata
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wdata;
  end
endmodule

// File: rtl/window3x3_linebuf.sv
// Streaming 3x3 neighbourhood generator (VALID border).
// Two row-delay buffers feed a 3-column shift register; a window is
// registered out for every transfer at x>=2, y>=2.
// Optional: WIN3_EOF_FLAG_EN adds o_eof, set on the last window of a frame.
module window3x3_linebuf
  import win3_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic                iClk,
  input logic                iRst,
  window3x3_linebuf_if.slave s
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  pix_t          lb0_rd, lb1_rd;
  win_t          win_q, win_d;
  logic          xfer, emit;

  // no skid buffer: accept only if the output slot is free or draining
  assign s.i_ready = ~s.o_valid | s.o_ready;
  assign xfer      = s.i_valid & s.i_ready;
  assign emit      = xfer && (x >= XW'(2)) && (y >= YW'(2));

  // LB0 holds row y-2, LB1 holds row y-1; LB1's old entry ages into LB0
  win3_line_buffer #(.DEPTH(IMG_W), .W(PIX_BITS)) u_lb0 (
    .clk(iClk), .en(xfer), .addr(x), .wdata(lb1_rd), .rdata(lb0_rd)
  );
  win3_line_buffer #(.DEPTH(IMG_W), .W(PIX_BITS)) u_lb1 (
    .clk(iClk), .en(xfer), .addr(x), .wdata(s.i_pix), .rdata(lb1_rd)
  );

  // next window: shift columns left, new right column from buffers + input
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb0_rd;
    win_d[1][2] = lb1_rd;
    win_d[2][2] = s.i_pix;
  end

  // raster position of the next accepted pixel; frame implied by the count
  always_ff @(posedge iClk) begin
    if (iRst) begin
      x <= '0;
      y <= '0;
    end else if (xfer) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // column shift register, frozen while stalled
  always_ff @(posedge iClk) begin
    if (iRst)      win_q <= '0;
    else if (xfer) win_q <= win_d;
  end

  // output register: load on an emitting transfer, hold until consumed
  always_ff @(posedge iClk) begin
    if (iRst) begin
      s.o_valid  <= 1'b0;
      s.o_window <= '0;
    end else if (emit) begin
      s.o_valid  <= 1'b1;
      s.o_window <= win_d;
    end else if (s.o_ready) begin
      s.o_valid  <= 1'b0;
    end
  end

`ifdef WIN3_EOF_FLAG_EN
  // end-of-frame tag travels with the window it belongs to
  always_ff @(posedge iClk) begin
    if (iRst)      s.o_eof <= 1'b0;
    else if (emit) s.o_eof <= (x == X_LAST) && (y == Y_LAST);
  end
`endif
endmodule

// File: tb/tb_window3x3_linebuf.sv
// Scoreboard bench for window3x3_linebuf: a 4x4 instance and an 8x4
// instance. Drivers push expected windows at issue time; per-DUT monitors
// pop and compare on every accepted output.
module tb_window3x3_linebuf;
  import win3_pkg::*;

  typedef struct packed {
    logic                eof;
    logic [WIN_BITS-1:0] w;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  window3x3_linebuf_if if4();
  window3x3_linebuf_if if8();

  window3x3_linebuf #(.IMG_W(4), .IMG_H(4)) dut4 (.iClk(clk), .iRst(rst), .s(if4));
  window3x3_linebuf #(.IMG_W(8), .IMG_H(4)) dut8 (.iClk(clk), .iRst(rst), .s(if8));

  logic [1:0]          d_valid, d_ordy;
  logic [PIX_BITS-1:0] d_pix [2];
  logic [1:0]          m_irdy, m_ovld;
  logic [WIN_BITS-1:0] m_win [2];

  assign if4.i_pix   = d_pix[0];
  assign if4.i_valid = d_valid[0];
  assign if4.o_ready = d_ordy[0];
  assign if8.i_pix   = d_pix[1];
  assign if8.i_valid = d_valid[1];
  assign if8.o_ready = d_ordy[1];
  assign m_irdy[0] = if4.i_ready;
  assign m_irdy[1] = if8.i_ready;
  assign m_ovld[0] = if4.o_valid;
  assign m_ovld[1] = if8.o_valid;
  assign m_win[0]  = if4.o_window;
  assign m_win[1]  = if8.o_window;
`ifdef WIN3_EOF_FLAG_EN
  logic [1:0] m_eof;
  assign m_eof[0] = if4.o_eof;
  assign m_eof[1] = if8.o_eof;
`endif

  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0, n_bad = 0;
  int n_win [2];
  int first_vld_cyc [2];
  int xfer22_cyc [2];
  int n_stall_rdy [2];
  logic [WIN_BITS-1:0] first_win, last_win;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // window whose bottom-right pixel is (x,y), pixel value = W*y+x on all channels
  function automatic logic [WIN_BITS-1:0] exp_win(input int W, input int x, input int y);
    win_t w;
    logic [7:0] b;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        b = 8'(W * (y - 2 + r) + (x - 2 + c));
        w[r][c] = {b, b, b};
      end
    return w;
  endfunction

  task automatic reset_stats(input int k);
    n_win[k] = 0;
    first_vld_cyc[k] = -1;
    xfer22_cyc[k] = -1;
    n_stall_rdy[k] = 0;
  endtask

  task automatic send_pix(input int k, input int W, input int H, input int x, input int y);
    int tries = 0;
    logic [7:0] b;
    exp_t e;
    b = 8'(W * y + x);
    forever begin
      @(negedge clk);
      d_valid[k] = 1'b1;
      d_pix[k] = {b, b, b};
      #1;
      if (m_irdy[k]) break;
      n_stall_rdy[k]++;
      if (++tries > 200) begin tmo("send_pix"); break; end
    end
    if (x == 2 && y == 2) xfer22_cyc[k] = cyc + 1;
    if (x >= 2 && y >= 2) begin
      e.w = exp_win(W, x, y);
      e.eof = (x == W - 1) && (y == H - 1);
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic send_rows(input int k, input int W, input int H, input int y0, input int y1);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = 0; xx < W; xx++)
        send_pix(k, W, H, xx, yy);
  endtask

  task automatic drain(input int k);
    int t = 0;
    @(negedge clk);
    d_valid[k] = 1'b0;
    while (((k == 0 ? q0.size() : q1.size()) != 0 || m_ovld[k]) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) tmo("drain");
  endtask

  task automatic stall_ctl(input int k, input int nth, input int cycles, input bit chk_eof);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(m_ovld[k] && n_win[k] == nth - 1) && t < 300);
    if (t >= 300) begin tmo("stall_wait"); return; end
    d_ordy[k] = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (i > 0) @(negedge clk);
      #4;
      check("stall_i_ready", m_irdy[k], 1'b0);
      if ((k == 0 ? q0.size() : q1.size()) == 0) tmo("stall_queue");
      else check("stall_hold_window", m_win[k], (k == 0) ? q0[0].w : q1[0].w);
`ifdef WIN3_EOF_FLAG_EN
      if (chk_eof) check("stall_hold_eof", m_eof[k], 1'b1);
`else
      if (chk_eof) check("stall_no_eof_build", 1'b0, 1'b1);
`endif
    end
    @(negedge clk);
    d_ordy[k] = 1'b1;
  endtask

  task automatic monitor(input int k);
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst) continue;
      if (m_ovld[k] && first_vld_cyc[k] < 0) first_vld_cyc[k] = cyc;
      if (m_ovld[k] && d_ordy[k]) begin
        n_win[k]++;
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          tmo("unexpected_window");
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          check(k == 0 ? "window4x4" : "window8x4", m_win[k], e.w);
`ifdef WIN3_EOF_FLAG_EN
          check("eof", m_eof[k], e.eof);
`endif
        end
        if (k == 0) begin
          if (n_win[0] == 1) first_win = m_win[0];
          last_win = m_win[0];
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    d_valid = '0;
    d_ordy = 2'b11;
    d_pix[0] = '0;
    d_pix[1] = '0;
    reset_stats(0);
    reset_stats(1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #4;
    // reset state
    check("rst_o_valid4", m_ovld[0], 1'b0);
    check("rst_o_window4", m_win[0], '0);
    check("rst_i_ready4", m_irdy[0], 1'b1);
    check("rst_o_valid8", m_ovld[1], 1'b0);
`ifdef WIN3_EOF_FLAG_EN
    check("rst_o_eof", m_eof[0], 1'b0);
`endif

    // basic 4x4 frame
    reset_stats(0);
    send_rows(0, 4, 4, 0, 3);
    drain(0);
    check("basic_count", n_win[0], 4);
    check("first_p00", first_win[23:0], 24'h000000);
    check("first_p11", first_win[119:96], 24'h050505);
    check("first_p22", first_win[215:192], 24'h0A0A0A);
    check("last_p22", last_win[215:192], 24'h0F0F0F);

    // backpressure on the first window
    reset_stats(0);
    fork
      send_rows(0, 4, 4, 0, 3);
      stall_ctl(0, 1, 5, 1'b0);
    join
    drain(0);
    check("bp_count", n_win[0], 4);

    // continuous throughput on 8x4
    reset_stats(1);
    send_rows(1, 8, 4, 0, 3);
    drain(1);
    check("thru_count", n_win[1], 12);
    check("thru_no_stall", n_stall_rdy[1], 0);
    check("thru_latency", first_vld_cyc[1], xfer22_cyc[1]);

    // back-to-back frames
    reset_stats(0);
    send_rows(0, 4, 4, 0, 3);
    send_rows(0, 4, 4, 0, 1);
    check("b2b_rows01_quiet", n_win[0], 4);
    send_rows(0, 4, 4, 2, 3);
    drain(0);
    check("b2b_count", n_win[0], 8);

    // reset in the middle of row 2 with an output pending
    reset_stats(0);
    send_rows(0, 4, 4, 0, 1);
    d_ordy[0] = 1'b0;
    send_pix(0, 4, 4, 0, 2);
    send_pix(0, 4, 4, 1, 2);
    send_pix(0, 4, 4, 2, 2);
    @(negedge clk);
    d_valid[0] = 1'b0;
    rst = 1'b1;
    #4;
    check("pre_rst_pending", m_ovld[0], 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #4;
    check("post_rst_o_valid", m_ovld[0], 1'b0);
    check("post_rst_i_ready", m_irdy[0], 1'b1);
    q0.delete();
    d_ordy[0] = 1'b1;
    reset_stats(0);
    send_rows(0, 4, 4, 0, 3);
    drain(0);
    check("post_rst_count", n_win[0], 4);

`ifdef WIN3_EOF_FLAG_EN
    // eof on the last window, held through a stall
    reset_stats(0);
    fork
      send_rows(0, 4, 4, 0, 3);
      stall_ctl(0, 4, 3, 1'b1);
    join
    drain(0);
    check("eof_count", n_win[0], 4);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
